// File: rtl/fp_adder_pkg.sv
// Shared widths, constants and status-flag type for the FP adder post-normalisation datapath.
package fp_adder_pkg;

    localparam int MANT_W_DEF = 24;
    localparam int EXP_W_DEF  = 8;
    localparam int TAG_W_DEF  = 4;

    localparam logic [EXP_W_DEF-1:0] EXP_ALL_ONES = 8'hFF;

    typedef struct packed {
        logic zero;
        logic underflow;
        logic overflow;
        logic sticky;
    } status_flags_t;

    function automatic status_flags_t flags_none();
        return status_flags_t'(4'b0000);
    endfunction

endpackage

// File: rtl/fp_adder_lzc.sv
// Combinational leading-zero counter; an all-zero input reports MANT_W.
module fp_adder_lzc #(
    parameter  int MANT_W = 24,
    localparam int LZC_W  = $clog2(MANT_W + 1)
) (
    input  logic [MANT_W-1:0] mant,
    output logic [LZC_W-1:0]  lzc
);

    logic [LZC_W-1:0] lzc_s;

    // Scan upward so the highest set bit is the last to win.
    always_comb begin
        lzc_s = LZC_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (mant[i]) begin
                lzc_s = LZC_W'(MANT_W - 1 - i);
            end else begin
                lzc_s = lzc_s;
            end
        end
    end

    assign lzc = lzc_s;

endmodule

// File: rtl/fp_adder_normalizer.sv
// Two-stage post-addition normaliser: LZC in stage 1, shift/exponent/flags in stage 2,
// with a valid/ready handshake that stalls cleanly under back-pressure.
module fp_adder_normalizer
    import fp_adder_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [MANT_W:0]                in_mant,
    input  logic [EXP_W-1:0]               in_exp,
    input  logic [TAG_W-1:0]               in_tag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [MANT_W-1:0]              out_mant,
    output logic [EXP_W-1:0]               out_exp,
    output logic [$clog2(MANT_W+1)-1:0]    out_lzc,
    output logic                           out_zero,
    output logic                           out_underflow,
    output logic                           out_overflow,
    output logic                           out_sticky,
    output logic [TAG_W-1:0]               out_tag
);

    localparam int LZC_W = $clog2(MANT_W + 1);
    localparam int XW    = EXP_W + 1;
    localparam logic [EXP_W-1:0] ALL_ONES = {EXP_W{1'b1}};

    logic              s1_valid_r;
    logic [MANT_W:0]   s1_mant_r;
    logic [EXP_W-1:0]  s1_exp_r;
    logic [TAG_W-1:0]  s1_tag_r;
    logic [LZC_W-1:0]  s1_lzc_r;

    logic              out_valid_r;
    logic [MANT_W-1:0] out_mant_r;
    logic [EXP_W-1:0]  out_exp_r;
    logic [LZC_W-1:0]  out_lzc_r;
    status_flags_t     out_flags_r;
    logic [TAG_W-1:0]  out_tag_r;

    logic [LZC_W-1:0]  in_lzc_s;
    logic              s2_ready_s;
    logic              s1_load_s;
    logic              s2_load_s;

    logic [XW-1:0]     exp_x_s;
    logic [XW-1:0]     lzc_x_s;
    logic [XW-1:0]     exp_inc_s;
    logic [XW-1:0]     shift_s;
    logic [MANT_W-1:0] nxt_mant_s;
    logic [EXP_W-1:0]  nxt_exp_s;
    logic [LZC_W-1:0]  nxt_lzc_s;
    status_flags_t     nxt_flags_s;

    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    assign s2_ready_s = !out_valid_r || out_ready;
    assign in_ready   = !s1_valid_r || s2_ready_s;
    assign s1_load_s  = in_valid && in_ready;
    assign s2_load_s  = s1_valid_r && s2_ready_s;

    fp_adder_lzc #(.MANT_W(MANT_W)) u_lzc (
        .mant (in_mant[MANT_W-1:0]),
        .lzc  (in_lzc_s)
    );

    // Stage 1: capture the raw sum, exponent, tag and its leading-zero count.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_mant_r  <= '0;
            s1_exp_r   <= '0;
            s1_tag_r   <= '0;
            s1_lzc_r   <= '0;
        end else if (s1_load_s) begin
            s1_valid_r <= 1'b1;
            s1_mant_r  <= in_mant;
            s1_exp_r   <= in_exp;
            s1_tag_r   <= in_tag;
            s1_lzc_r   <= in_lzc_s;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2 datapath: exponent math at EXP_W+1 bits so nothing wraps.
    always_comb begin
        exp_x_s     = {1'b0, s1_exp_r};
        lzc_x_s     = XW'(s1_lzc_r);
        exp_inc_s   = exp_x_s + XW'(1);
        shift_s     = '0;
        nxt_mant_s  = '0;
        nxt_exp_s   = '0;
        nxt_lzc_s   = s1_lzc_r;
        nxt_flags_s = flags_none();
        if (s1_mant_r[MANT_W]) begin
            nxt_lzc_s          = '0;
            nxt_flags_s.sticky = s1_mant_r[0];
            if (exp_inc_s >= {1'b0, ALL_ONES}) begin
                nxt_flags_s.overflow = 1'b1;
                nxt_exp_s            = ALL_ONES;
            end else begin
                nxt_mant_s = s1_mant_r[MANT_W:1];
                nxt_exp_s  = exp_inc_s[EXP_W-1:0];
            end
        end else if (s1_lzc_r == LZC_W'(MANT_W)) begin
            nxt_flags_s.zero = 1'b1;
            nxt_lzc_s        = LZC_W'(MANT_W);
        end else begin
            // Shift is clamped at the exponent; the excess leaves a denormal.
            if (lzc_x_s > exp_x_s) begin
                nxt_flags_s.underflow = 1'b1;
                shift_s               = exp_x_s;
            end else begin
                shift_s = lzc_x_s;
            end
            nxt_mant_s = s1_mant_r[MANT_W-1:0] << shift_s;
            nxt_exp_s  = EXP_W'(exp_x_s - shift_s);
        end
    end

    // Stage 2: output registers, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_mant_r  <= '0;
            out_exp_r   <= '0;
            out_lzc_r   <= '0;
            out_flags_r <= flags_none();
            out_tag_r   <= '0;
        end else if (s2_ready_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_mant_r  <= nxt_mant_s;
                out_exp_r   <= nxt_exp_s;
                out_lzc_r   <= nxt_lzc_s;
                out_flags_r <= nxt_flags_s;
                out_tag_r   <= s1_tag_r;
            end
        end
    end

    assign out_valid     = out_valid_r;
    assign out_mant      = out_mant_r;
    assign out_exp       = out_exp_r;
    assign out_lzc       = out_lzc_r;
    assign out_zero      = out_flags_r.zero;
    assign out_underflow = out_flags_r.underflow;
    assign out_overflow  = out_flags_r.overflow;
    assign out_sticky    = out_flags_r.sticky;
    assign out_tag       = out_tag_r;

endmodule
